arb_request_agent: RTL and testbench

Client-side front end for the N-way priority arbiter. Accumulates per-client transaction requests in saturating pending counters, presents request-vector snapshots to the arbiter, and tracks the arbiter's one-hot grants through its stall window. Retires one pending transaction per grant, reports each grant as an encoded client ID, and flags protocol violations.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/arb_pend_cnt.sv | 32 +++
 rtl/arb_request_agent.sv | 129 ++++++++++++
 tb/tb_arb_request_agent.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter request agent: state encoding
// and one-hot utilities used when checking and retiring grants.
`timescale 1ns/1ps
package arb_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_agent_state_t;

    // Vectors are passed zero-extended to 32 bits so one helper serves any N up to 32.
    function automatic int onehot_to_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/arb_pend_cnt.sv
// One client's pending-transaction counter: saturating up/down with a
// single-cycle pulse when an increment hits the ceiling.
`timescale 1ns/1ps
module arb_pend_cnt #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_nz,
    output logic o_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_nz  = (r_cnt != '0);
    assign o_ovf = i_inc && !i_dec && (r_cnt == CNT_MAX);

endmodule

// File: rtl/arb_request_agent.sv
// Client-side front end of the priority arbiter: issues request snapshots,
// retires one pending transaction per accepted grant, flags protocol errors.
`timescale 1ns/1ps
module arb_request_agent
    import arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         client_req,
    output logic [N-1:0]         request,
    input  logic [N-1:0]         grant,
    input  logic                 stall,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [N-1:0]         pending_nz,
    output logic                 overflow,
    output logic                 proto_err
);

    localparam int IDW = $clog2(N);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_agent_state_t r_state;
    logic [N-1:0]     r_request;
    logic [N-1:0]     r_snap;
    logic [TW-1:0]    r_timer;
    logic             r_grant_valid;
    logic [IDW-1:0]   r_grant_id;
    logic             r_overflow;
    logic             r_proto_err;

    logic [N-1:0]     w_nz;
    logic [N-1:0]     w_ovf;
    logic [N-1:0]     w_dec;
    logic [N-1:0]     w_snap_after;
    logic             w_grant_any;
    logic             w_grant_ok;

    // Only a one-hot grant that hits a still-outstanding snapshot bit is retired.
    assign w_grant_any  = (grant != '0);
    assign w_grant_ok   = (r_state == WAIT) && is_onehot(32'(grant)) && ((grant & r_snap) != '0);
    assign w_dec        = w_grant_ok ? grant : '0;
    assign w_snap_after = r_snap & ~w_dec;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cnt
            arb_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .i_inc (client_req[gi]),
                .i_dec (w_dec[gi]),
                .o_nz  (w_nz[gi]),
                .o_ovf (w_ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_request     <= '0;
            r_snap        <= '0;
            r_timer       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_overflow    <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            r_grant_valid <= 1'b0;
            if (w_ovf != '0) r_overflow <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_grant_any) r_proto_err <= 1'b1;
                    if (!stall && (w_nz != '0)) begin
                        r_snap    <= w_nz;
                        r_request <= w_nz;
                        r_timer   <= '0;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_grant_any) r_proto_err <= 1'b1;
                    if (stall) begin
                        r_request <= '0;
                        r_state   <= WAIT;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        // Arbiter never picked up the snapshot; abandon it.
                        r_request   <= '0;
                        r_snap      <= '0;
                        r_proto_err <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                WAIT: begin
                    if (w_grant_any) begin
                        if (w_grant_ok) begin
                            r_grant_valid <= 1'b1;
                            r_grant_id    <= IDW'(onehot_to_idx(32'(grant)));
                        end else begin
                            r_proto_err <= 1'b1;
                        end
                    end
                    r_snap <= w_snap_after;
                    if (!stall) begin
                        if (w_snap_after != '0) r_proto_err <= 1'b1;
                        r_snap  <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign request     = r_request;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign pending_nz  = w_nz;
    assign overflow    = r_overflow;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_arb_request_agent.sv
// Self-checking bench for arb_request_agent: an arbiter-side stimulus plus a
// retire scoreboard that pops expected client IDs on every grant_valid.
`timescale 1ns/1ps
module tb_arb_request_agent;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] client_req = 8'h00;
    logic [7:0] grant = 8'h00;
    logic       stall = 1'b0;
    logic [7:0] request;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic [7:0] pending_nz;
    logic       overflow;
    logic       proto_err;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    arb_request_agent #(.N(8), .CNT_W(4), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .client_req  (client_req),
        .request     (request),
        .grant       (grant),
        .stall       (stall),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pending_nz  (pending_nz),
        .overflow    (overflow),
        .proto_err   (proto_err)
    );

    // Retire scoreboard
    always @(negedge clk) begin
        if (grant_valid) begin
            int e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL retire_unexpected: grant_id=%0d, required no retire", grant_id);
            end else begin
                e = exp_q.pop_front();
                if (grant_id !== 3'(e)) begin
                    n_bad++;
                    $display("FAIL retire_id: grant_id=%0d, required %0d", grant_id, e);
                end else begin
                    $display("retire client %0d", grant_id);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        client_req = 8'h00;
        grant = 8'h00;
        stall = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse(input logic [7:0] m);
        client_req = m;
        step();
        client_req = 8'h00;
    endtask

    task automatic wait_req(output bit seen);
        for (int i = 0; i < 20; i++) begin
            if (request != 8'h00) break;
            step();
        end
        seen = (request != 8'h00);
    endtask

    task automatic check_q_empty(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_unretired: %0d grants outstanding, required 0", name, exp_q.size());
        end
    endtask

    // One full arbiter handshake: observe snapshot, stall, grant each bit, release.
    task automatic serve_one(input logic [7:0] exp);
        bit seen;
        wait_req(seen);
        n_cmp++;
        if (!seen || request !== exp) begin
            n_bad++;
            $display("FAIL issue_request: request=%h, required %h", request, exp);
            return;
        end
        step();
        n_cmp++;
        if (request !== exp) begin
            n_bad++;
            $display("FAIL request_hold: request=%h, required %h", request, exp);
        end
        stall = 1'b1;
        step();
        n_cmp++;
        if (request !== 8'h00) begin
            n_bad++;
            $display("FAIL request_clear: request=%h, required 00", request);
        end
        for (int b = 0; b < 8; b++) begin
            if (exp[b]) begin
                grant = 8'b1 << b;
                exp_q.push_back(b);
                step();
            end
        end
        grant = 8'h00;
        stall = 1'b0;
        step();
        $display("snapshot %h served", exp);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        client_req = 8'hFF;
        grant = 8'h3C;
        step();
        step();
        n_cmp++;
        if (request !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 3'd0 ||
            pending_nz !== 8'h00 || overflow !== 1'b0 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: req=%h gv=%b id=%0d pnz=%h ovf=%b perr=%b, required all 0",
                     request, grant_valid, grant_id, pending_nz, overflow, proto_err);
        end
        client_req = 8'h00;
        grant = 8'h00;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_issue_drain();
        do_reset();
        pulse(8'h05);
        n_cmp++;
        if (pending_nz !== 8'h05 || request !== 8'h00) begin
            n_bad++;
            $display("FAIL accept_req: pnz=%h req=%h, required 05 00", pending_nz, request);
        end
        serve_one(8'h05);
        step();
        n_cmp++;
        if (pending_nz !== 8'h00 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_end: pnz=%h perr=%b, required 00 0", pending_nz, proto_err);
        end
        check_q_empty("issue_drain");
        $display("test_issue_drain done");
    endtask

    task automatic test_accumulate();
        bit seen;
        int retired;
        do_reset();
        pulse(8'h08);
        pulse(8'h08);
        pulse(8'h08);
        wait_req(seen);
        n_cmp++;
        if (!seen || request !== 8'h08) begin
            n_bad++;
            $display("FAIL acc_first_snap: request=%h, required 08", request);
        end
        stall = 1'b1;
        step();
        grant = 8'h08;
        exp_q.push_back(3);
        step();
        grant = 8'h00;
        client_req = 8'h08;
        step();
        client_req = 8'h00;
        stall = 1'b0;
        step();
        retired = 1;
        for (int i = 0; i < 8; i++) begin
            if (pending_nz == 8'h00) break;
            serve_one(8'h08);
            retired++;
        end
        step();
        n_cmp++;
        if (retired !== 4 || pending_nz !== 8'h00 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL accumulate: retired=%0d pnz=%h perr=%b, required 4 00 0",
                     retired, pending_nz, proto_err);
        end
        check_q_empty("accumulate");
        $display("test_accumulate done");
    endtask

    task automatic test_overflow();
        int drained;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 15; i++) pulse(8'h02);
        n_cmp++;
        if (overflow !== 1'b0 || pending_nz !== 8'h02) begin
            n_bad++;
            $display("FAIL ovf_before: ovf=%b pnz=%h, required 0 02", overflow, pending_nz);
        end
        pulse(8'h02);
        n_cmp++;
        if (overflow !== 1'b1 || pending_nz !== 8'h02) begin
            n_bad++;
            $display("FAIL ovf_after: ovf=%b pnz=%h, required 1 02", overflow, pending_nz);
        end
        stall = 1'b0;
        drained = 0;
        for (int i = 0; i < 20; i++) begin
            if (pending_nz == 8'h00) break;
            serve_one(8'h02);
            drained++;
        end
        n_cmp++;
        if (drained !== 15 || proto_err !== 1'b0 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_saturate: drained=%0d perr=%b ovf=%b, required 15 0 1",
                     drained, proto_err, overflow);
        end
        check_q_empty("overflow");
        $display("test_overflow done");
    endtask

    task automatic test_bad_grant();
        bit seen;
        do_reset();
        pulse(8'h02);
        wait_req(seen);
        stall = 1'b1;
        step();
        grant = 8'h10;
        step();
        grant = 8'h00;
        n_cmp++;
        if (grant_valid !== 1'b0 || proto_err !== 1'b1 || pending_nz !== 8'h02) begin
            n_bad++;
            $display("FAIL bad_grant: gv=%b perr=%b pnz=%h, required 0 1 02",
                     grant_valid, proto_err, pending_nz);
        end
        stall = 1'b0;
        step();
        // Fresh run: no grant at all before stall falls.
        do_reset();
        pulse(8'h02);
        wait_req(seen);
        stall = 1'b1;
        step();
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL missing_grant_early: perr=%b, required 0", proto_err);
        end
        stall = 1'b0;
        step();
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_bad++;
            $display("FAIL missing_grant: perr=%b, required 1", proto_err);
        end
        check_q_empty("bad_grant");
        $display("test_bad_grant done");
    endtask

    task automatic test_timeout();
        bit seen;
        int cnt;
        do_reset();
        pulse(8'h20);
        wait_req(seen);
        cnt = 0;
        while (request == 8'h20 && cnt < 200) begin
            cnt++;
            step();
        end
        n_cmp++;
        if (cnt !== 64 || request !== 8'h00 || proto_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout: cycles=%0d req=%h perr=%b, required 64 00 1",
                     cnt, request, proto_err);
        end
        step();
        n_cmp++;
        if (request !== 8'h20) begin
            n_bad++;
            $display("FAIL timeout_reissue: request=%h, required 20", request);
        end
        stall = 1'b1;
        step();
        grant = 8'h20;
        exp_q.push_back(5);
        step();
        grant = 8'h00;
        stall = 1'b0;
        step();
        n_cmp++;
        if (pending_nz !== 8'h00) begin
            n_bad++;
            $display("FAIL timeout_drain: pnz=%h, required 00", pending_nz);
        end
        check_q_empty("timeout");
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        do_reset();
        pulse(8'h03);
        wait_req(seen);
        n_cmp++;
        if (request !== 8'h03) begin
            n_bad++;
            $display("FAIL rst_snap: request=%h, required 03", request);
        end
        stall = 1'b1;
        step();
        grant = 8'h01;
        exp_q.push_back(0);
        step();
        grant = 8'h02;
        reset = 1'b1;
        step();
        n_cmp++;
        if (request !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 3'd0 ||
            pending_nz !== 8'h00 || overflow !== 1'b0 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_wait: req=%h gv=%b id=%0d pnz=%h ovf=%b perr=%b, required all 0",
                     request, grant_valid, grant_id, pending_nz, overflow, proto_err);
        end
        reset = 1'b0;
        grant = 8'h00;
        stall = 1'b0;
        check_q_empty("reset_mid_wait");
        pulse(8'h04);
        wait_req(seen);
        n_cmp++;
        if (request !== 8'h04 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_issue: req=%h perr=%b, required 04 0", request, proto_err);
        end
        $display("test_reset_mid_wait done");
    endtask

    initial begin
        test_reset();
        test_issue_drain();
        test_accumulate();
        test_overflow();
        test_bad_grant();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
